apb_master_ctrl: RTL and testbench

- APB master stage of the AHB-to-APB bridge; sits directly upstream of the 8-slave APB bus.
- Accepts one transfer request at a time from the bridge's AHB-side request path over a valid/ready handshake.
- Decodes the target slave, runs the APB SETUP/ACCESS sequence with wait-state support and selects that slave's PRDATA/PSLVERR.
- Returns a one-cycle response pulse; decode misses and wait-state timeouts come back as errors.

---
 rtl/apb_bridge_pkg.sv | 25 ++
 rtl/apb_master_ctrl_if.sv | 32 +++
 rtl/apb_addr_decode.sv | 22 ++
 rtl/apb_master_ctrl.sv | 141 ++++++++++++++
 tb/tb_apb_master_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge APB master stage.
package apb_bridge_pkg;

  localparam int unsigned NUM_SLV_C = 8;
  localparam int unsigned SLV_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DECERR
  } apb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } apb_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Request/response handshake plus the 8-slave APB bus of the master stage.
interface apb_master_ctrl_if;
  import apb_bridge_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [31:0]          req_addr;
  logic                 req_write;
  logic [31:0]          req_wdata;
  logic                 rsp_valid;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;
  logic [31:0]          PADDR;
  logic                 PWRITE;
  logic [31:0]          PWDATA;
  logic [NUM_SLV_C-1:0] PSELx;
  logic                 PENABLE;
  logic [31:0]          PRDATA [NUM_SLV_C-1:0];
  logic [NUM_SLV_C-1:0] PREADY;
  logic [NUM_SLV_C-1:0] PSLVERR;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWRITE, PWDATA, PSELx, PENABLE
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWRITE, PWDATA, PSELx, PENABLE
  );

endinterface

// File: rtl/apb_addr_decode.sv
// Maps a transfer address onto a slave index, a region hit flag and a one-hot select.
module apb_addr_decode
  import apb_bridge_pkg::*;
#(
  parameter int unsigned SLV_IDX_LSB = 12,
  parameter logic [31:0] REGION_BASE = 32'h0000_0000
) (
  input  logic [31:SLV_IDX_LSB]   addr_i,
  output logic [SLV_IDX_W-1:0]    idx_o,
  output logic                    hit_o,
  output logic [NUM_SLV_C-1:0]    sel_o
);

  // Index field, region compare above it, and one-hot select gated by the hit.
  always_comb begin
    idx_o = addr_i[SLV_IDX_LSB+2:SLV_IDX_LSB];
    hit_o = (addr_i[31:SLV_IDX_LSB+3] == REGION_BASE[31:SLV_IDX_LSB+3]);
    sel_o = '0;
    if (hit_o) sel_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master stage: accepts one request, runs SETUP/ACCESS with wait states and a
// timeout, and returns a one-cycle response. All bus outputs are registered.
module apb_master_ctrl
  import apb_bridge_pkg::*;
#(
  parameter int unsigned NUM_SLV     = 8,
  parameter int unsigned SLV_IDX_LSB = 12,
  parameter logic [31:0] REGION_BASE = 32'h0000_0000,
  parameter int unsigned TIMEOUT     = 16
) (
  input logic         clk,
  input logic         rst_n,
  apb_master_ctrl_if.master bus
);

  apb_state_e           state_q, state_d;
  apb_req_t             req_q, req_d;
  apb_rsp_t             rsp_q, rsp_d;
  logic [SLV_IDX_W-1:0] idx_q, idx_d;
  logic [NUM_SLV-1:0]   psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          cnt_q, cnt_d;

  logic [SLV_IDX_W-1:0] dec_idx;
  logic                 dec_hit;
  logic [NUM_SLV_C-1:0] dec_sel;
  logic                 slv_ready;
  logic                 slv_err;

  apb_addr_decode #(
    .SLV_IDX_LSB (SLV_IDX_LSB),
    .REGION_BASE (REGION_BASE)
  ) u_decode (
    .addr_i (bus.req_addr[31:SLV_IDX_LSB]),
    .idx_o  (dec_idx),
    .hit_o  (dec_hit),
    .sel_o  (dec_sel)
  );

  // Only the addressed slave's handshake is ever looked at.
  assign slv_ready = bus.PREADY[idx_q];
  assign slv_err   = bus.PSLVERR[idx_q];

  // Next-state, bus controls and response for the transfer sequence.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    idx_d       = idx_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_d       = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          req_d = '{addr: bus.req_addr, write: bus.req_write, wdata: bus.req_wdata};
          idx_d = dec_idx;
          if (dec_hit) begin
            state_d = SETUP;
            psel_d  = dec_sel;
            cnt_d   = '0;
          end else begin
            state_d = DECERR;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (slv_ready) begin
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_d.err   = slv_err;
          rsp_d.rdata = (!req_q.write && !slv_err) ? bus.PRDATA[idx_q] : '0;
        end else if (TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th stalled ACCESS cycle: abort at this edge.
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_d.err   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DECERR: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_d.err   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Registered so that it reads 0 while reset is held.
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      rsp_q       <= '0;
      idx_q       <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_q       <= rsp_d;
      idx_q       <= idx_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_q.rdata;
  assign bus.rsp_err   = rsp_q.err;
  assign bus.PADDR     = req_q.addr;
  assign bus.PWRITE    = req_q.write;
  assign bus.PWDATA    = req_q.wdata;
  assign bus.PSELx     = psel_q;
  assign bus.PENABLE   = penable_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed cases plus random transfers against a
// cycle-count reference model; other slaves are driven with random noise.
module tb_apb_master_ctrl;
  import apb_bridge_pkg::*;

  localparam int unsigned TO    = 16;
  localparam int          NEVER = -1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  apb_master_ctrl_if bus ();

  apb_master_ctrl #(
    .NUM_SLV     (8),
    .SLV_IDX_LSB (12),
    .REGION_BASE (32'h0000_0000),
    .TIMEOUT     (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic slave_noise();
    bus.PREADY  = 8'($urandom);
    bus.PSLVERR = 8'($urandom);
    for (int i = 0; i < 8; i++) bus.PRDATA[i] = $urandom;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!bus.req_ready && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_wait", 64'(bus.req_ready), 64'(1));
  endtask

  // Model: hit -> 1 SETUP cycle, A ACCESS cycles (waits+1, or TO on timeout),
  // response in the cycle after; miss -> 1 DECERR cycle, response after it.
  task automatic do_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input int waits, input logic slverr, input logic [31:0] rdata);
    logic [2:0]  idx;
    logic        hit, tmo, exp_err, in_setup, in_access;
    logic [7:0]  sel;
    logic [31:0] exp_rdata;
    logic [10:0] exp_vec;
    int          a, rsp_n;
    idx       = addr[14:12];
    hit       = (addr[31:15] == 17'h0);
    tmo       = (waits == NEVER) || (waits >= int'(TO));
    a         = tmo ? int'(TO) : waits + 1;
    sel       = hit ? (8'b1 << idx) : 8'h00;
    rsp_n     = hit ? a + 2 : 2;
    exp_err   = !hit || tmo || slverr;
    exp_rdata = (!wr && !exp_err) ? rdata : 32'h0;

    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_write = wr;
    bus.req_wdata = wdata;
    slave_noise();
    bus.PREADY[idx] = 1'b0;
    @(negedge clk);
    for (int n = 1; n <= rsp_n + 1; n++) begin
      in_setup  = hit && (n == 1);
      in_access = hit && (n >= 2) && (n < rsp_n);
      exp_vec   = {(n >= rsp_n), (n == rsp_n), in_access, (in_setup || in_access) ? sel : 8'h00};
      check($sformatf("bus_a%08h_n%0d", addr, n),
            64'({bus.req_ready, bus.rsp_valid, bus.PENABLE, bus.PSELx}), 64'(exp_vec));
      if (hit && n == 1) begin
        check("paddr", 64'({bus.PWRITE, bus.PADDR}), 64'({wr, addr}));
        check("pwdata", 64'(bus.PWDATA), 64'(wdata));
      end
      if (n == rsp_n) check($sformatf("rsp_a%08h", addr),
                            64'({bus.rsp_err, bus.rsp_rdata}), 64'({exp_err, exp_rdata}));
      // Drive inputs for cycle n; request lines are junk until the DUT is ready again.
      slave_noise();
      bus.req_valid = (n < rsp_n) ? 1'($urandom) : 1'b0;
      bus.req_addr  = $urandom;
      bus.req_write = 1'($urandom);
      bus.req_wdata = $urandom;
      if (hit) begin
        bus.PREADY[idx] = (n >= 2) && !tmo && (n - 1 == waits + 1);
        if (bus.PREADY[idx]) begin
          bus.PSLVERR[idx] = slverr;
          bus.PRDATA[idx]  = rdata;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic reset_mid_access();
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_4008;
    bus.req_write = 1'b0;
    slave_noise();
    bus.PREADY[4] = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    slave_noise();
    bus.PREADY[4] = 1'b0;
    @(negedge clk);
    check("access_before_rst", 64'({bus.PENABLE, bus.PSELx}), 64'({1'b1, 8'h10}));
    bus.PREADY[4] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_async", 64'({bus.req_ready, bus.rsp_valid, bus.PENABLE, bus.PSELx}), 64'(0));
    for (int i = 0; i < 2; i++) begin
      bus.PREADY = 8'hFF;
      @(negedge clk);
      check("rst_hold", 64'({bus.req_ready, bus.rsp_valid, bus.PENABLE, bus.PSELx}), 64'(0));
    end
    bus.PREADY = 8'h00;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst", 64'({bus.rsp_valid, bus.PENABLE, bus.PSELx}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] hi;
    logic [2:0]  ridx;
    int          rw;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_write = 1'b0;
    bus.req_wdata = '0;
    bus.PREADY    = '0;
    bus.PSLVERR   = '0;
    for (int i = 0; i < 8; i++) bus.PRDATA[i] = '0;
    #1;
    check("reset_ctl", 64'({bus.req_ready, bus.rsp_valid, bus.PENABLE, bus.PSELx}), 64'(0));
    check("reset_data", 64'({bus.rsp_err, bus.rsp_rdata, bus.PWRITE, bus.PADDR}), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_cycle", 64'({bus.PENABLE, bus.PSELx}), 64'(0));

    do_txn(32'h0000_3010, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    do_txn(32'h0000_7004, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678);
    do_txn(32'h0000_2000, 1'b0, 32'h0, 2, 1'b1, 32'hCAFE_F00D);
    do_txn(32'h0001_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    do_txn(32'h0000_1000, 1'b0, 32'h0, NEVER, 1'b0, 32'h0);
    do_txn(32'h0000_5000, 1'b0, 32'h0, int'(TO) - 1, 1'b0, 32'h0BAD_F00D);
    reset_mid_access();
    do_txn(32'h0000_6ffc, 1'b0, 32'h0, 1, 1'b0, 32'hA5A5_5A5A);

    for (int t = 0; t < 40; t++) begin
      hi   = ($urandom_range(0, 4) == 0) ? 17'($urandom_range(1, 17'h1FFFF)) : 17'h0;
      ridx = 3'($urandom);
      rw   = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 5));
      do_txn({hi, ridx, 12'($urandom)}, 1'($urandom), $urandom, rw,
             ($urandom_range(0, 3) == 0), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
